// File: rtl/biquad_pkg.sv
// rtl/biquad_pkg.sv - shared constants and types for the biquad MAC sequencer
package biquad_pkg;

  localparam int MUL_LAT = 2;
  localparam int ACC_W   = 19;
  localparam int NTAPS   = 5;
  // Taps at or above this index are the feedback terms and are subtracted.
  localparam int FB_TAP  = 3;

  localparam logic signed [15:0] Q14_MAX = 16'sh7FFF;
  localparam logic signed [15:0] Q14_MIN = 16'sh8000;

  localparam logic [2:0] CFG_B0 = 3'd0;
  localparam logic [2:0] CFG_B1 = 3'd1;
  localparam logic [2:0] CFG_B2 = 3'd2;
  localparam logic [2:0] CFG_A1 = 3'd3;
  localparam logic [2:0] CFG_A2 = 3'd4;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_t;

endpackage

// File: rtl/q14_sat.sv
// rtl/q14_sat.sv - clips a wide signed accumulator to the Q2.14 range
module q14_sat
  import biquad_pkg::*;
#(
  parameter int IN_W = ACC_W
) (
  input  logic signed [IN_W-1:0] acc,
  output logic signed [15:0]     sat
);

  // In range exactly when every bit above bit 15 repeats the sign bit.
  always_comb begin
    if (acc[IN_W-1:15] == {(IN_W-15){acc[IN_W-1]}}) begin
      sat = acc[15:0];
    end else if (acc[IN_W-1]) begin
      sat = Q14_MIN;
    end else begin
      sat = Q14_MAX;
    end
  end

endmodule

// File: rtl/biquad_mac_sequencer.sv
// rtl/biquad_mac_sequencer.sv - shares one pipelined Q2.14 multiplier across the
// five products of a direct-form-I biquad, accumulating and saturating the result
module biquad_mac_sequencer
  import biquad_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  input  logic        cfg_we,
  output logic        cfg_ready,
  input  logic [2:0]  cfg_addr,
  input  logic [15:0] cfg_data,
  input  logic        hist_clr,
  output logic [15:0] mul_a,
  output logic [15:0] mul_b,
  output logic        mul_valid,
  input  logic [15:0] mul_p,
  input  logic        mul_pvalid
);

  state_t state, state_next;

  logic signed [15:0]      coef [NTAPS];
  logic signed [15:0]      x0, x1, x2, y1, y2;
  logic [2:0]              iss_cnt, ret_cnt, ret_cnt_next, next_tap;
  logic signed [ACC_W-1:0] acc, acc_next, prod_ext;
  logic signed [15:0]      y_sat, tap_a, tap_b, b0_eff;
  logic                    cfg_wr, accept, issue_step, issue_done;
  logic                    prod_take, result_load, out_fire;

  assign cfg_wr    = cfg_we && (state == IDLE);
  assign prod_take = mul_pvalid && ((state == ISSUE) || (state == DRAIN));
  assign prod_ext  = {{(ACC_W-16){mul_p[15]}}, mul_p};
  assign next_tap  = iss_cnt + 3'd1;
  // A b0 write in the accept cycle must reach tap 0, which is loaded on that edge.
  assign b0_eff    = (cfg_wr && cfg_addr == CFG_B0) ? $signed(cfg_data) : coef[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    in_ready    = 1'b0;
    cfg_ready   = 1'b0;
    accept      = 1'b0;
    issue_step  = 1'b0;
    issue_done  = 1'b0;
    result_load = 1'b0;
    out_fire    = 1'b0;
    case (state)
      IDLE: begin
        in_ready  = 1'b1;
        cfg_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (iss_cnt == 3'(NTAPS-1)) begin
          issue_done = 1'b1;
          state_next = DRAIN;
        end else begin
          issue_step = 1'b1;
        end
      end
      DRAIN: begin
        // Register the result on the same edge the last product lands.
        if (ret_cnt_next == 3'(NTAPS)) begin
          result_load = 1'b1;
          state_next  = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          out_fire   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tap_a = x0;
    tap_b = coef[0];
    case (next_tap)
      3'd1: begin tap_a = x1; tap_b = coef[1]; end
      3'd2: begin tap_a = x2; tap_b = coef[2]; end
      3'd3: begin tap_a = y1; tap_b = coef[3]; end
      3'd4: begin tap_a = y2; tap_b = coef[4]; end
      default: ;
    endcase
  end

  always_comb begin
    acc_next     = acc;
    ret_cnt_next = ret_cnt;
    if (prod_take) begin
      ret_cnt_next = ret_cnt + 3'd1;
      if (ret_cnt >= 3'(FB_TAP)) begin
        acc_next = acc - prod_ext;
      end else begin
        acc_next = acc + prod_ext;
      end
    end
  end

  q14_sat #(.IN_W(ACC_W)) u_sat (
    .acc (acc_next),
    .sat (y_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NTAPS; i++) coef[i] <= '0;
    end else begin
      for (int i = 0; i < NTAPS; i++) begin
        if (cfg_wr && cfg_addr == 3'(i)) coef[i] <= cfg_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x1 <= '0;
      x2 <= '0;
      y1 <= '0;
      y2 <= '0;
    end else if (state == IDLE && hist_clr) begin
      x1 <= '0;
      x2 <= '0;
      y1 <= '0;
      y2 <= '0;
    end else if (out_fire) begin
      x2 <= x1;
      x1 <= x0;
      y2 <= y1;
      y1 <= out_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x0        <= '0;
      iss_cnt   <= '0;
      ret_cnt   <= '0;
      acc       <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_valid <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (accept) begin
        x0        <= in_data;
        iss_cnt   <= '0;
        ret_cnt   <= '0;
        acc       <= '0;
        mul_a     <= in_data;
        mul_b     <= b0_eff;
        mul_valid <= 1'b1;
      end else begin
        if (issue_step) begin
          iss_cnt <= next_tap;
          mul_a   <= tap_a;
          mul_b   <= tap_b;
        end
        if (issue_done) mul_valid <= 1'b0;
        if (prod_take) begin
          ret_cnt <= ret_cnt_next;
          acc     <= acc_next;
        end
      end
      if (result_load) begin
        out_valid <= 1'b1;
        out_data  <= y_sat;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_biquad_mac_sequencer.sv
// tb/tb_biquad_mac_sequencer.sv - scoreboard bench with a saturating pipelined
// multiplier stand-in and an equation-level biquad reference model
module tb_biquad_mac_sequencer;

  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        cfg_we = 1'b0;
  logic        cfg_ready;
  logic [2:0]  cfg_addr = '0;
  logic [15:0] cfg_data = '0;
  logic        hist_clr = 1'b0;
  logic [15:0] mul_a, mul_b, mul_p;
  logic        mul_valid, mul_pvalid;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int pulse_cnt = 0;

  logic [15:0] m_coef [5];
  logic [15:0] m_x1 = '0, m_x2 = '0, m_y1 = '0, m_y2 = '0;
  logic [15:0] exp_q [$];
  logic [15:0] obs_q [$];
  int          acc_cyc_q [$];

  logic [15:0] p1 = '0, p2 = '0;
  logic        p1_v = 1'b0, p2_v = 1'b0;

  biquad_mac_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .cfg_we     (cfg_we),
    .cfg_ready  (cfg_ready),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .hist_clr   (hist_clr),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_valid  (mul_valid),
    .mul_p      (mul_p),
    .mul_pvalid (mul_pvalid)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] qmul(input logic [15:0] a, input logic [15:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    p = p >>> 14;
    if (p > 32767) p = 32767;
    else if (p < -32768) p = -32768;
    return 16'(p);
  endfunction

  function automatic logic [15:0] model_y(input logic [15:0] x);
    logic [15:0]        ops [5];
    logic signed [15:0] pr;
    int                 acc;
    ops = '{x, m_x1, m_x2, m_y1, m_y2};
    acc = 0;
    for (int k = 0; k < 5; k++) begin
      pr = qmul(ops[k], m_coef[k]);
      if (k < 3) acc = acc + int'(pr);
      else acc = acc - int'(pr);
    end
    if (acc > 32767) acc = 32767;
    else if (acc < -32768) acc = -32768;
    return 16'(acc);
  endfunction

  // External multiplier: fixed two-stage pipeline, deliberately not reset.
  always @(posedge clk) begin
    p1_v <= mul_valid;
    p1   <= qmul(mul_a, mul_b);
    p2_v <= p1_v;
    p2   <= p1;
    cyc  <= cyc + 1;
    if (mul_valid) pulse_cnt <= pulse_cnt + 1;
  end
  assign mul_p      = p2;
  assign mul_pvalid = p2_v;

  always @(negedge clk) begin
    logic [15:0] y, e;
    if (!rst) begin
      if (in_valid && in_ready) begin
        y = model_y(in_data);
        exp_q.push_back(y);
        acc_cyc_q.push_back(cyc);
        m_x2 = m_x1; m_x1 = in_data;
        m_y2 = m_y1; m_y1 = y;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL scoreboard_unexpected out_data=%h required=no output", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e) $display("FAIL scoreboard out_data=%h required=%h", out_data, e);
          else passes++;
        end
        obs_q.push_back(out_data);
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 5; i++) m_coef[i] = '0;
    m_x1 = '0; m_x2 = '0; m_y1 = '0; m_y2 = '0;
    exp_q.delete();
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [15:0] d);
    int n = 0;
    while (!cfg_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!cfg_ready) begin checks++; $display("FAIL cfg_wait cfg_ready=0 required=1"); end
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    if (a < 3'd5) m_coef[a] = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic set_coefs(input logic [15:0] b0, b1, b2, a1, a2);
    cfg_write(3'd0, b0); cfg_write(3'd1, b1); cfg_write(3'd2, b2);
    cfg_write(3'd3, a1); cfg_write(3'd4, a2);
  endtask

  task automatic clear_hist();
    int n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin checks++; $display("FAIL clr_wait in_ready=0 required=1"); end
    hist_clr = 1'b1;
    m_x1 = '0; m_x2 = '0; m_y1 = '0; m_y2 = '0;
    @(posedge clk); #1;
    hist_clr = 1'b0;
  endtask

  task automatic drive_sample(input logic [15:0] x, input bit with_cfg,
                              input logic [2:0] ca, input logic [15:0] cd, input bit with_clr);
    int n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin checks++; $display("FAIL accept_wait in_ready=0 required=1"); end
    in_valid = 1'b1; in_data = x;
    if (with_cfg) begin
      cfg_we = 1'b1; cfg_addr = ca; cfg_data = cd;
      if (ca < 3'd5) m_coef[ca] = cd;
    end
    if (with_clr) begin
      hist_clr = 1'b1;
      m_x1 = '0; m_x2 = '0; m_y1 = '0; m_y2 = '0;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; cfg_we = 1'b0; hist_clr = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    int n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    lat = n;
    if (!out_valid) begin checks++; $display("FAIL out_wait out_valid=0 required=1"); end
  endtask

  task automatic take_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic send(input logic [15:0] x);
    int lat;
    drive_sample(x, 1'b0, 3'd0, 16'h0, 1'b0);
    wait_out(lat);
    take_out();
  endtask

  task automatic test_reset();
    logic [51:0] got;
    logic [51:0] req;
    int          lat;
    req = {4'b1100, 48'h0};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    got = {in_ready, cfg_ready, out_valid, mul_valid, out_data, mul_a, mul_b};
    checks++;
    if (got !== req) $display("FAIL reset_por outputs=%h required=%h", got, req);
    else passes++;
    // Reset while a result is held in OUT.
    set_coefs(16'h4000, 16'h0, 16'h0, 16'h0, 16'h0);
    drive_sample(16'h2000, 1'b0, 3'd0, 16'h0, 1'b0);
    wait_out(lat);
    rst = 1'b1;
    #1;
    got = {in_ready, cfg_ready, out_valid, mul_valid, out_data, mul_a, mul_b};
    checks++;
    if (got !== req) $display("FAIL reset_mid_frame outputs=%h required=%h", got, req);
    else passes++;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_pass_through();
    int lat, p0;
    set_coefs(16'h4000, 16'h0, 16'h0, 16'h0, 16'h0);
    clear_hist();
    p0 = pulse_cnt;
    drive_sample(16'h2000, 1'b0, 3'd0, 16'h0, 1'b0);
    wait_out(lat);
    checks++;
    if (lat != MUL_LAT + 5) $display("FAIL pass_latency edges=%0d required=%0d", lat, MUL_LAT + 5);
    else passes++;
    checks++;
    if (out_data !== 16'h2000) $display("FAIL pass_data out_data=%h required=2000", out_data);
    else passes++;
    checks++;
    if (pulse_cnt - p0 != 5) $display("FAIL pass_pulses mul_valid=%0d required=5", pulse_cnt - p0);
    else passes++;
    take_out();
  endtask

  task automatic test_recursion();
    logic [15:0] lit [4];
    lit = '{16'h4000, 16'h2000, 16'h1000, 16'h0800};
    set_coefs(16'h4000, 16'h0, 16'h0, 16'hE000, 16'h0);
    clear_hist();
    obs_q.delete();
    send(16'h4000); send(16'h0); send(16'h0); send(16'h0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_q.size() <= i) $display("FAIL recursion_%0d out_data=none required=%h", i, lit[i]);
      else if (obs_q[i] !== lit[i]) $display("FAIL recursion_%0d out_data=%h required=%h", i, obs_q[i], lit[i]);
      else passes++;
    end
  endtask

  task automatic test_saturation();
    set_coefs(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0, 16'h0);
    clear_hist();
    obs_q.delete();
    repeat (3) send(16'h7FFF);
    set_coefs(16'h8001, 16'h8001, 16'h8001, 16'h0, 16'h0);
    clear_hist();
    repeat (3) send(16'h7FFF);
    checks++;
    if (obs_q.size() < 6 || obs_q[2] !== 16'h7FFF) $display("FAIL sat_pos out_data=%h required=7fff", obs_q.size() > 2 ? obs_q[2] : 16'hxxxx);
    else passes++;
    checks++;
    if (obs_q.size() < 6 || obs_q[5] !== 16'h8000) $display("FAIL sat_neg out_data=%h required=8000", obs_q.size() > 5 ? obs_q[5] : 16'hxxxx);
    else passes++;
  endtask

  task automatic test_backpressure();
    int          lat;
    logic [15:0] held;
    set_coefs(16'h4000, 16'h0, 16'h0, 16'h0, 16'h0);
    clear_hist();
    obs_q.delete();
    drive_sample(16'h1000, 1'b0, 3'd0, 16'h0, 1'b0);
    wait_out(lat);
    held = out_data;
    checks++;
    if (held !== 16'h1000) $display("FAIL bp_first out_data=%h required=1000", held);
    else passes++;
    for (int i = 0; i < 10; i++) begin
      cfg_we = (i == 2); cfg_addr = 3'd0; cfg_data = 16'h7FFF;
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, cfg_ready} !== 3'b100 || out_data !== held)
        $display("FAIL bp_hold_%0d valid/in_ready/cfg_ready/data=%b%b%b/%h required=100/%h",
                 i, out_valid, in_ready, cfg_ready, out_data, held);
      else passes++;
    end
    cfg_we = 1'b0;
    take_out();
    send(16'h1000);
    checks++;
    if (obs_q.size() < 2 || obs_q[1] !== 16'h1000) $display("FAIL bp_cfg_dropped out_data=%h required=1000", obs_q.size() > 1 ? obs_q[1] : 16'hxxxx);
    else passes++;
  endtask

  task automatic test_same_cycle();
    int lat;
    set_coefs(16'h4000, 16'h4000, 16'h0, 16'h2000, 16'h0);
    clear_hist();
    send(16'h3000);
    obs_q.delete();
    drive_sample(16'h2000, 1'b1, 3'd0, 16'h2000, 1'b1);
    wait_out(lat);
    take_out();
    checks++;
    if (obs_q.size() < 1 || obs_q[0] !== 16'h1000) $display("FAIL same_cycle out_data=%h required=1000", obs_q.size() > 0 ? obs_q[0] : 16'hxxxx);
    else passes++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] xs [3];
    int          n;
    xs = '{16'h0100, 16'h0200, 16'h0300};
    set_coefs(16'h4000, 16'h0, 16'h0, 16'h0, 16'h0);
    clear_hist();
    acc_cyc_q.delete();
    out_ready = 1'b1; in_valid = 1'b1; in_data = xs[0];
    n = 0;
    while (acc_cyc_q.size() < 3 && n < 100) begin
      @(posedge clk); #1; n++;
      if (acc_cyc_q.size() < 3) in_data = xs[acc_cyc_q.size()];
    end
    in_valid = 1'b0;
    while (exp_q.size() > 0 && n < 200) begin @(posedge clk); #1; n++; end
    out_ready = 1'b0;
    if (acc_cyc_q.size() < 3 || exp_q.size() > 0) begin
      checks++;
      $display("FAIL b2b_timeout accepts=%0d pending=%0d required=3/0", acc_cyc_q.size(), exp_q.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (acc_cyc_q[i] - acc_cyc_q[i-1] != MUL_LAT + 7)
          $display("FAIL b2b_period_%0d cycles=%0d required=%0d", i, acc_cyc_q[i] - acc_cyc_q[i-1], MUL_LAT + 7);
        else passes++;
      end
    end
  endtask

  task automatic test_reset_mid_op();
    logic [51:0] got;
    logic [51:0] req;
    req = {4'b1100, 48'h0};
    set_coefs(16'h4000, 16'h4000, 16'h4000, 16'h2000, 16'h2000);
    send(16'h1000);
    drive_sample(16'h2000, 1'b0, 3'd0, 16'h0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (mul_valid !== 1'b1) $display("FAIL rst_op_issuing mul_valid=%b required=1", mul_valid);
    else passes++;
    rst = 1'b1;
    #1;
    got = {in_ready, cfg_ready, out_valid, mul_valid, out_data, mul_a, mul_b};
    checks++;
    if (got !== req) $display("FAIL rst_op_outputs outputs=%h required=%h", got, req);
    else passes++;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    obs_q.delete();
    send(16'h4000);
    checks++;
    if (obs_q.size() < 1 || obs_q[0] !== 16'h0000) $display("FAIL rst_op_next out_data=%h required=0000", obs_q.size() > 0 ? obs_q[0] : 16'hxxxx);
    else passes++;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_pass_through();
    test_recursion();
    test_saturation();
    test_backpressure();
    test_same_cycle();
    test_back_to_back();
    test_reset_mid_op();
    checks++;
    if (exp_q.size() != 0) $display("FAIL drain pending=%0d required=0", exp_q.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/biquad_mac_sequencer.md
# biquad_mac_sequencer

Time-multiplexes one external pipelined Q2.14 multiplier across the five coefficient products of a direct-form-I biquad section. It holds the coefficient and history registers, issues one product per cycle, accumulates the returned products, and saturates the result to Q2.14. It sits between the sample stream (valid/ready on both sides) and the shared multiplier instance of an IIR stage.

## Interface
- MUL_LAT, 2: cycles from a `mul_valid` issue to the matching `mul_pvalid`. Fixed latency, results returned in order.
- ACC_W, 19: signed accumulator width, Q5.14.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input sample valid.
- in_ready  out  1  high only in IDLE.
- in_data  in  16  x[n], signed Q2.14.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  downstream accept.
- out_data  out  16  y[n], signed Q2.14, saturated.
- cfg_we  in  1  coefficient write strobe; honoured only when `cfg_ready` is high.
- cfg_ready  out  1  high only in IDLE.
- cfg_addr  in  3  0=b0, 1=b1, 2=b2, 3=a1, 4=a2; addresses 5–7 are ignored.
- cfg_data  in  16  coefficient, signed Q2.14.
- hist_clr  in  1  in IDLE, zeroes x1, x2, y1, y2 (coefficients kept).
- mul_a  out  16  operand 1: sample/history value.
- mul_b  out  16  operand 2: coefficient.
- mul_valid  out  1  issue strobe.
- mul_p  in  16  product, signed Q2.14.
- mul_pvalid  in  1  product valid.

## Operation
- Equation: y = b0·x + b1·x1 + b2·x2 − a1·y1 − a2·y2.
- Tap order k = 0..4: (x, b0), (x1, b1), (x2, b2), (y1, a1), (y2, a2).
- Taps 3 and 4 are subtracted from the accumulator; taps 0–2 are added. Products are sign-extended to ACC_W before the add or subtract.
- The accumulator cannot overflow: 5 × 2^15 < 2^18.
- Final result: the accumulator clipped to [0x8000, 0x7FFF] and registered into `out_data`.
- On output handshake: x2←x1, x1←x, y2←y1, y1←the saturated y.
- State machine:
  - IDLE: on `in_valid` && `in_ready`, latch x, clear the accumulator and both counters, go to ISSUE.
  - ISSUE: drive tap k with `mul_valid`=1. The issue counter runs 0..4. After k=4 go to DRAIN.
  - DRAIN: wait until the return counter reaches 5, then register the result with `out_valid`=1 and go to OUT.
  - OUT: hold `out_valid`/`out_data` until `out_ready`, then update history and go to IDLE.
- The return counter and accumulator update on every `mul_pvalid` in ISSUE or DRAIN.
- `mul_pvalid` in IDLE or OUT is ignored and does not touch the accumulator.
- Configuration:
  - A `cfg_we` write in IDLE is written the same edge.
  - A `cfg_we` write outside IDLE is dropped; writers must observe `cfg_ready`.
  - `cfg_we` and an input accept in the same IDLE cycle: both take effect, and the new coefficient is used for this sample.
- `hist_clr` and an input accept in the same cycle: the history is cleared first, and this sample uses zero history.
- Reset values:
  - All registers, coefficients and history are 0, and state is IDLE.
  - `in_ready`=1, `cfg_ready`=1, `out_valid`=0, `out_data`=0, `mul_valid`=0, `mul_a`/`mul_b`=0.
- Reset mid-operation: the FSM returns to IDLE immediately and the sample is lost. Products still in flight are ignored because of the IDLE rule.

## Timing
- Input accepted at edge t.
- Tap k is issued in cycle t+1+k.
- Products return in cycles t+1+k+MUL_LAT.
- `out_valid` rises at t+6+MUL_LAT (t+8 at the default).
- `in_ready` returns the cycle after the output handshake. Minimum sample period is 7+MUL_LAT cycles.
- `mul_a`/`mul_b` hold their last value when `mul_valid`=0.
- `out_data` is stable while `out_valid`=1 && !`out_ready`.

## Structure
- Shared package biquad_pkg holds:
  - Q14_MAX = 16'sh7FFF and Q14_MIN = 16'sh8000.
  - NTAPS = 5.
  - The cfg address constants.
  - The FSM state enum (IDLE, ISSUE, DRAIN, OUT).
- One sub-module, q14_sat: clips ACC_W to 16 bits. It is reused by other IIR blocks.
- The multiplier is external, not instantiated here.

## Test plan
- **Reset:** assert `rst` mid-frame, then release. Required: all outputs at reset values, `in_ready`=1.
- **Pass-through:** b0=0x4000, all other coefficients 0, x=0x2000. Required: `out_data`=0x2000 exactly 8 cycles after the accept; exactly five `mul_valid` pulses.
- **Recursion:** b0=0x4000, a1=0xE000 (−0.5), impulse x=0x4000 then zeros. Required: outputs 0x4000, 0x2000, 0x1000, 0x0800.
- **Saturation:** b0=b1=b2=0x7FFF, three samples of 0x7FFF. Required: third output 0x7FFF; negated coefficients give 0x8000.
- **Backpressure:** hold `out_ready` low for 10 cycles. Required: `out_valid`/`out_data` stable, `in_ready`=0, a `cfg_we` to b0 is dropped (next result unchanged).
- **Reset mid-operation:** assert `rst` at the third ISSUE cycle. Required: late `mul_pvalid` is ignored; the next sample is computed with zero history and zero coefficients, giving 0x0000.
